// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency instruction memory and fills IF/ID.
// Optional ecall halt is compiled in with `define FETCH_ECALL_HALT_EN.
module fetch_stage #(
    parameter int                AWIDTH   = 32,
    parameter int                DWIDTH   = 32,
    parameter logic [AWIDTH-1:0] RESET_PC = AWIDTH'(32'h01000000)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_o,
    output logic [AWIDTH-1:0] imem_addr_o,
    input  logic [DWIDTH-1:0] imem_rdata_i,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    output logic [AWIDTH-1:0] f_pc_o,
    output logic [DWIDTH-1:0] f_insn_o,
    output logic              f_valid_o,
    output logic              halted_o
);

    localparam logic [DWIDTH-1:0] NOP      = DWIDTH'(32'h00000013);
    localparam logic [AWIDTH-1:0] PC_STEP  = AWIDTH'(4);
    localparam logic [AWIDTH-1:0] WORD_MSK = ~AWIDTH'(3);

    logic [AWIDTH-1:0] pc_q, pc_d;
    logic [AWIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_valid_q, inflight_valid_d;
    logic [AWIDTH-1:0] f_pc_q, f_pc_d;
    logic [DWIDTH-1:0] f_insn_q, f_insn_d;
    logic              f_valid_q, f_valid_d;
    logic              halted_q;

`ifdef FETCH_ECALL_HALT_EN
    localparam logic [DWIDTH-1:0] ECALL = DWIDTH'(32'h00000073);
    logic halted_d;
`else
    assign halted_q = 1'b0;
`endif

    // Control inputs are level-sampled on every rising edge, no handshake:
    // redirect_i beats stall_i, stall_i beats advance. A stall re-presents the
    // in-flight address so the memory returns that word again next cycle.
    assign imem_req_o  = reset & ~halted_q;
    assign imem_addr_o = (stall_i && inflight_valid_q && !redirect_i) ? inflight_pc_q : pc_q;

    always_comb begin
        pc_d             = pc_q;
        inflight_pc_d    = inflight_pc_q;
        inflight_valid_d = inflight_valid_q;
        f_pc_d           = f_pc_q;
        f_insn_d         = f_insn_q;
        f_valid_d        = f_valid_q;
`ifdef FETCH_ECALL_HALT_EN
        halted_d         = halted_q;
`endif
        if (redirect_i) begin
            pc_d             = redirect_pc_i & WORD_MSK;
            inflight_valid_d = 1'b0;
            f_valid_d        = 1'b0;
            f_insn_d         = NOP;
`ifdef FETCH_ECALL_HALT_EN
            halted_d         = 1'b0;
`endif
        end else if (stall_i) begin
            inflight_valid_d = inflight_valid_q & ~halted_q;
        end else if (halted_q) begin
            // Decode has taken the ecall; leave a bubble behind it.
            inflight_valid_d = 1'b0;
            f_valid_d        = 1'b0;
            f_insn_d         = NOP;
        end else begin
            f_pc_d           = inflight_pc_q;
            f_insn_d         = inflight_valid_q ? imem_rdata_i : NOP;
            f_valid_d        = inflight_valid_q;
            inflight_pc_d    = pc_q;
            inflight_valid_d = 1'b1;
            pc_d             = pc_q + PC_STEP;
`ifdef FETCH_ECALL_HALT_EN
            halted_d         = inflight_valid_q && (imem_rdata_i == ECALL);
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q             <= RESET_PC;
            inflight_pc_q    <= '0;
            inflight_valid_q <= 1'b0;
            f_pc_q           <= '0;
            f_insn_q         <= NOP;
            f_valid_q        <= 1'b0;
        end else begin
            pc_q             <= pc_d;
            inflight_pc_q    <= inflight_pc_d;
            inflight_valid_q <= inflight_valid_d;
            f_pc_q           <= f_pc_d;
            f_insn_q         <= f_insn_d;
            f_valid_q        <= f_valid_d;
        end
    end

`ifdef FETCH_ECALL_HALT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) halted_q <= 1'b0;
        else        halted_q <= halted_d;
    end
`endif

    assign f_pc_o    = f_pc_q;
    assign f_insn_o  = f_insn_q;
    assign f_valid_o = f_valid_q;
    assign halted_o  = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: two instances (default RESET_PC and a wrapping one)
// share control inputs; each has its own 1-cycle memory model mem[a] = a ^ 32'hA5A5A5A5.
module tb_fetch_stage;

    localparam logic [31:0] R   = 32'h01000000;
    localparam logic [31:0] R2  = 32'hFFFFFFF8;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        req1, req2;
    logic [31:0] addr1, addr2;
    logic [31:0] rdata1, rdata2;
    logic [31:0] f_pc1, f_pc2;
    logic [31:0] f_insn1, f_insn2;
    logic        f_valid1, f_valid2;
    logic        halted1, halted2;
    logic        ecall_en;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp2_q[$];

    fetch_stage dut (
        .clk(clk), .reset(reset),
        .imem_req_o(req1), .imem_addr_o(addr1), .imem_rdata_i(rdata1),
        .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .f_pc_o(f_pc1), .f_insn_o(f_insn1), .f_valid_o(f_valid1), .halted_o(halted1)
    );

    fetch_stage #(.RESET_PC(R2)) dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req_o(req2), .imem_addr_o(addr2), .imem_rdata_i(rdata2),
        .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .f_pc_o(f_pc2), .f_insn_o(f_insn2), .f_valid_o(f_valid2), .halted_o(halted2)
    );

    // ---------------- clock / memory model ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (ecall_en && a == 32'h01000008) return 32'h00000073;
        return a ^ 32'hA5A5A5A5;
    endfunction

    always @(posedge clk) begin
        rdata1 <= mem_word(addr1);
        rdata2 <= mem_word(addr2);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; ecall_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++; if (f_valid1 !== 1'b0) $display("FAIL reset_valid got=%b exp=0", f_valid1); else pass_cnt++;
        total_cnt++; if (f_insn1 !== NOP) $display("FAIL reset_insn got=%h exp=%h", f_insn1, NOP); else pass_cnt++;
        total_cnt++; if (f_pc1 !== 32'h0) $display("FAIL reset_pc got=%h exp=0", f_pc1); else pass_cnt++;
        total_cnt++; if (req1 !== 1'b0) $display("FAIL reset_req got=%b exp=0", req1); else pass_cnt++;
        total_cnt++; if (halted1 !== 1'b0) $display("FAIL reset_halted got=%b exp=0", halted1); else pass_cnt++;
        total_cnt++; if (addr1 !== R) $display("FAIL reset_addr got=%h exp=%h", addr1, R); else pass_cnt++;
        reset = 1'b1;
    endtask

    // Reset was just released between edges; expects the first valid word after the 2nd edge.
    task automatic run_restart(input string tag);
        logic [31:0] e, e2;
        tick();
        total_cnt++; if (f_valid1 !== 1'b0) $display("FAIL %s_edge1_valid got=%b exp=0", tag, f_valid1); else pass_cnt++;
        total_cnt++; if (req1 !== 1'b1) $display("FAIL %s_req got=%b exp=1", tag, req1); else pass_cnt++;
        exp_q  = '{R, R + 32'd4, R + 32'd8};
        exp2_q = '{R2, R2 + 32'd4, 32'h00000000};
        for (int i = 0; i < 3; i++) begin
            tick();
            e  = exp_q.pop_front();
            e2 = exp2_q.pop_front();
            total_cnt++; if (f_pc1 !== e || f_valid1 !== 1'b1)
                $display("FAIL %s_pc[%0d] got=%h/%b exp=%h/1", tag, i, f_pc1, f_valid1, e); else pass_cnt++;
            total_cnt++; if (f_insn1 !== mem_word(e))
                $display("FAIL %s_insn[%0d] got=%h exp=%h", tag, i, f_insn1, mem_word(e)); else pass_cnt++;
            total_cnt++; if (f_pc2 !== e2 || f_valid2 !== 1'b1 || f_insn2 !== mem_word(e2))
                $display("FAIL %s_wrap[%0d] got=%h/%b/%h exp=%h/1/%h", tag, i, f_pc2, f_valid2, f_insn2, e2, mem_word(e2)); else pass_cnt++;
        end
    endtask

    task automatic test_stream();
        run_restart("stream");
    endtask

    task automatic test_stall();
        stall = 1'b1;
        #1;
        total_cnt++; if (addr1 !== R + 32'hC) $display("FAIL stall_addr got=%h exp=%h", addr1, R + 32'hC); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++; if (f_pc1 !== R + 32'h8 || f_valid1 !== 1'b1 || f_insn1 !== mem_word(R + 32'h8))
                $display("FAIL stall_hold[%0d] got=%h/%b/%h exp=%h/1/%h", i, f_pc1, f_valid1, f_insn1, R + 32'h8, mem_word(R + 32'h8)); else pass_cnt++;
        end
        stall = 1'b0;
        tick();
        total_cnt++; if (f_pc1 !== R + 32'hC || f_valid1 !== 1'b1 || f_insn1 !== mem_word(R + 32'hC))
            $display("FAIL stall_resume got=%h/%b/%h exp=%h/1/%h", f_pc1, f_valid1, f_insn1, R + 32'hC, mem_word(R + 32'hC)); else pass_cnt++;
        tick();
        total_cnt++; if (f_pc1 !== R + 32'h10 || f_insn1 !== mem_word(R + 32'h10))
            $display("FAIL stall_next got=%h/%h exp=%h/%h", f_pc1, f_insn1, R + 32'h10, mem_word(R + 32'h10)); else pass_cnt++;
    endtask

    // Drives a one-cycle redirect and checks bubble, bubble, target, target+4.
    task automatic do_redirect(input string tag, input logic [31:0] tgt, input logic [31:0] exp_pc);
        redirect = 1'b1; redirect_pc = tgt;
        tick();
        redirect = 1'b0; stall = 1'b0;
        total_cnt++; if (f_valid1 !== 1'b0 || f_insn1 !== NOP)
            $display("FAIL %s_bubble1 got=%b/%h exp=0/%h", tag, f_valid1, f_insn1, NOP); else pass_cnt++;
        total_cnt++; if (halted1 !== 1'b0 || req1 !== 1'b1)
            $display("FAIL %s_unhalt got=%b/%b exp=0/1", tag, halted1, req1); else pass_cnt++;
        tick();
        total_cnt++; if (f_valid1 !== 1'b0) $display("FAIL %s_bubble2 got=%b exp=0", tag, f_valid1); else pass_cnt++;
        tick();
        total_cnt++; if (f_pc1 !== exp_pc || f_valid1 !== 1'b1 || f_insn1 !== mem_word(exp_pc))
            $display("FAIL %s_target got=%h/%b/%h exp=%h/1/%h", tag, f_pc1, f_valid1, f_insn1, exp_pc, mem_word(exp_pc)); else pass_cnt++;
        tick();
        total_cnt++; if (f_pc1 !== exp_pc + 32'd4 || f_valid1 !== 1'b1)
            $display("FAIL %s_target4 got=%h/%b exp=%h/1", tag, f_pc1, f_valid1, exp_pc + 32'd4); else pass_cnt++;
    endtask

    task automatic test_redirect();
        do_redirect("redir", 32'h01000100, 32'h01000100);
    endtask

    task automatic test_redirect_stall();
        // After test_redirect: f_pc=0x104, in flight 0x108, pc 0x10C.
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h01000203;
        #1;
        total_cnt++; if (addr1 !== 32'h0100010C) $display("FAIL redir_stall_addr got=%h exp=0100010c", addr1); else pass_cnt++;
        do_redirect("redir_stall", 32'h01000203, 32'h01000200);
    endtask

    task automatic test_async_reset();
        #3;
        reset = 1'b0;
        #1;
        total_cnt++; if (f_valid1 !== 1'b0 || f_insn1 !== NOP || f_pc1 !== 32'h0)
            $display("FAIL async_reset got=%b/%h/%h exp=0/%h/0", f_valid1, f_insn1, f_pc1, NOP); else pass_cnt++;
        total_cnt++; if (f_valid2 !== 1'b0 || f_insn2 !== NOP)
            $display("FAIL async_reset_wrap got=%b/%h exp=0/%h", f_valid2, f_insn2, NOP); else pass_cnt++;
        tick();
        reset = 1'b1;
        run_restart("restart");
    endtask

    task automatic test_ecall();
        ecall_en = 1'b1;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        repeat (3) tick();
        tick();
        total_cnt++; if (f_pc1 !== R + 32'h8 || f_valid1 !== 1'b1 || f_insn1 !== 32'h00000073)
            $display("FAIL ecall_load got=%h/%b/%h exp=%h/1/00000073", f_pc1, f_valid1, f_insn1, R + 32'h8); else pass_cnt++;
`ifdef FETCH_ECALL_HALT_EN
        total_cnt++; if (halted1 !== 1'b1 || req1 !== 1'b0)
            $display("FAIL ecall_halt got=%b/%b exp=1/0", halted1, req1); else pass_cnt++;
        tick();
        total_cnt++; if (f_valid1 !== 1'b0 || f_insn1 !== NOP || halted1 !== 1'b1 || req1 !== 1'b0)
            $display("FAIL ecall_consumed got=%b/%h/%b/%b exp=0/%h/1/0", f_valid1, f_insn1, halted1, req1, NOP); else pass_cnt++;
        tick();
        total_cnt++; if (f_valid1 !== 1'b0 || halted1 !== 1'b1)
            $display("FAIL ecall_idle got=%b/%b exp=0/1", f_valid1, halted1); else pass_cnt++;
`else
        total_cnt++; if (halted1 !== 1'b0 || req1 !== 1'b1)
            $display("FAIL ecall_nohalt got=%b/%b exp=0/1", halted1, req1); else pass_cnt++;
        tick();
        total_cnt++; if (f_pc1 !== R + 32'hC || f_valid1 !== 1'b1 || f_insn1 !== mem_word(R + 32'hC))
            $display("FAIL ecall_flow got=%h/%b/%h exp=%h/1/%h", f_pc1, f_valid1, f_insn1, R + 32'hC, mem_word(R + 32'hC)); else pass_cnt++;
`endif
        do_redirect("ecall_redir", 32'h01000040, 32'h01000040);
        ecall_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_async_reset();
        test_ecall();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
